// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared definitions for the Sobel custom-instruction feeder: pixel and
//   magnitude widths, the number of pixels packed per custom-instruction
//   operand pair, and the feeder FSM state encoding.
//   Optional feature macro used by the importing files: SOBEL_FEEDER_THRESH_EN.
package sobel_pkg;

  localparam int PIX_PER_WORD = 8;   // pixels per custom-instruction call
  localparam int PIX_W        = 8;   // grayscale pixel width
  localparam int MAG_W        = 4;   // Sobel magnitude width in ci_result
  localparam int WORD_W       = 32;  // custom-instruction operand width

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_nibble_expand.sv
// sobel_nibble_expand
//   Combinational selection of one 4-bit magnitude from the packed
//   custom-instruction result and its expansion to an 8-bit output pixel.
//   Default build: the nibble is replicated ({n,n}), so 0xF -> 0xFF.
//   With SOBEL_FEEDER_THRESH_EN defined: the pixel is binarised,
//   0xFF when nibble >= THRESH, 0x00 otherwise.
// Ports
//   res  in  32  packed magnitudes, nibble k at res[4k+3:4k]
//   sel  in  3   nibble index k
//   pix  out 8   expanded output pixel
module sobel_nibble_expand
  import sobel_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESH = 4'd8
) (
  input  logic [WORD_W-1:0] res,
  input  logic [2:0]        sel,
  output logic [PIX_W-1:0]  pix
);

  function automatic logic [PIX_W-1:0] expand(input logic [MAG_W-1:0] n);
`ifdef SOBEL_FEEDER_THRESH_EN
    return (n >= THRESH) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    return {n, n};
`endif
  endfunction

`ifndef SOBEL_FEEDER_THRESH_EN
  // THRESH only matters in the threshold build; fold it into a dead sink.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  logic [MAG_W-1:0] nib;

  always_comb begin
    nib = res[sel*MAG_W +: MAG_W];
    pix = expand(nib);
  end

endmodule

// File: rtl/sobel_ci_feeder.sv
// sobel_ci_feeder
//   Collects eight raster-order grayscale pixels, hands them to the Sobel
//   custom instruction as two packed 32-bit operands, waits for completion,
//   then streams the eight returned 4-bit magnitudes out as 8-bit pixels.
//   Optional feature macro: SOBEL_FEEDER_THRESH_EN (binarise output pixels
//   against THRESH instead of nibble replication).
// Parameters
//   LINE_WIDTH  pixels per image line, multiple of 8
//   THRESH      binarisation threshold (threshold build only)
// Ports
//   clock, reset (async, active-low)
//   pix_in/pix_in_valid/pix_in_ready       input pixel stream
//   ci_dataa/ci_datab                      pixels 0-3 / 4-7, byte 0 first
//   ci_clock_en/ci_start                   custom-instruction control
//   ci_done/ci_result                      completion and packed magnitudes
//   pix_out/pix_out_valid/pix_out_ready    output pixel stream
//   line_end                               last output pixel of a line
//   busy                                   a group is partially/fully in flight
module sobel_ci_feeder
  import sobel_pkg::*;
#(
  parameter int               LINE_WIDTH = 64,
  parameter logic [MAG_W-1:0] THRESH     = 4'd8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  output logic [WORD_W-1:0] ci_dataa,
  output logic [WORD_W-1:0] ci_datab,
  output logic              ci_clock_en,
  output logic              ci_start,
  input  logic              ci_done,
  input  logic [WORD_W-1:0] ci_result,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_out_valid,
  input  logic              pix_out_ready,
  output logic              line_end,
  output logic              busy
);

  localparam int GROUPS = LINE_WIDTH / PIX_PER_WORD;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  state_t             state;
  logic [2:0]         fill_cnt;
  logic [2:0]         out_cnt;
  logic [GRP_W-1:0]   grp_cnt;
  logic [WORD_W-1:0]  res_q;
  logic [PIX_W-1:0]   exp_pix;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      out_cnt  <= '0;
      grp_cnt  <= '0;
      res_q    <= '0;
      ci_dataa <= '0;
      ci_datab <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          // pix_in_ready is 1 throughout FILL, so valid alone is a handshake.
          if (pix_in_valid) begin
            if (!fill_cnt[2])
              ci_dataa[fill_cnt[1:0]*PIX_W +: PIX_W] <= pix_in;
            else
              ci_datab[fill_cnt[1:0]*PIX_W +: PIX_W] <= pix_in;
            fill_cnt <= fill_cnt + 3'd1;  // wraps 7 -> 0 on the last pixel
            if (fill_cnt == 3'd7)
              state <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ci_done) begin
            res_q <= ci_result;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pix_out_ready) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd7) begin
              state   <= ST_FILL;
              grp_cnt <= (grp_cnt == GRP_LAST) ? '0 : grp_cnt + GRP_W'(1);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  sobel_nibble_expand #(
    .THRESH (THRESH)
  ) u_expand (
    .res (res_q),
    .sel (out_cnt),
    .pix (exp_pix)
  );

  // Outputs decode directly from the state register; operands stay frozen
  // outside FILL because only FILL writes them.
  assign pix_in_ready  = (state == ST_FILL);
  assign ci_start      = (state == ST_ISSUE);
  assign ci_clock_en   = (state == ST_ISSUE) || (state == ST_WAIT);
  assign pix_out_valid = (state == ST_DRAIN);
  assign pix_out       = (state == ST_DRAIN) ? exp_pix : '0;
  assign line_end      = (state == ST_DRAIN) && (out_cnt == 3'd7) && (grp_cnt == GRP_LAST);
  assign busy          = (state != ST_FILL) || (fill_cnt != 3'd0);

endmodule

// File: doc/sobel_ci_feeder.md
SOBEL_CI_FEEDER -- requirements
Module: sobel_ci_feeder

Interface
REQ-001 Parameter: LINE_WIDTH, 64, pixels per image line; SHALL be a multiple of 8.
REQ-002 Parameter: THRESH, 4'd8, binarisation threshold; SHALL be used only when SOBEL_FEEDER_THRESH_EN is defined.
REQ-003 clock  in  1  clock; SHALL be the only clock.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 pix_in  in  8  grayscale input pixel, raster order.
REQ-006 pix_in_valid  in  1 / pix_in_ready  out  1  input handshake.
REQ-007 ci_dataa  out  32 / ci_datab  out  32  packed pixels 0-3 and 4-7 to the Sobel custom instruction.
REQ-008 ci_clock_en  out  1 / ci_start  out  1  custom-instruction control.
REQ-009 ci_done  in  1 / ci_result  in  32  completion flag and eight packed 4-bit magnitudes.
REQ-010 pix_out  out  8 / pix_out_valid  out  1 / pix_out_ready  in  1  output stream.
REQ-011 line_end  out  1  marks the last output pixel of a line.
REQ-012 busy  out  1  high whenever a group is partially or fully in flight.

Function
REQ-013 The FSM SHALL have the states FILL, ISSUE, WAIT and DRAIN; reset state is FILL.
REQ-014 FILL: pix_in_ready=1; each handshake writes the pixel to byte fill_cnt[1:0] of dataa when fill_cnt<4, else to byte fill_cnt[1:0] of datab, then increments fill_cnt (3-bit).
REQ-015 The handshake that accepts the 8th pixel (fill_cnt=7) SHALL move the FSM to ISSUE and wrap fill_cnt to 0.
REQ-016 ISSUE: ci_start=1 for exactly one cycle; the next state SHALL be WAIT.
REQ-017 ci_clock_en SHALL be 1 in ISSUE and WAIT only; ci_dataa/ci_datab SHALL be stable from ISSUE until ci_done is sampled.
REQ-018 WAIT: ci_done=1 SHALL capture ci_result into res_q and move the FSM to DRAIN; ci_done SHALL be ignored in every other state.
REQ-019 DRAIN: pix_out_valid=1; pix_out SHALL be formed from nibble res_q[4k+3:4k], k=out_cnt, k=0 first; out_cnt SHALL advance only on valid&ready; valid and data SHALL hold while ready=0.
REQ-020 The handshake on k=7 SHALL return the FSM to FILL and increment grp_cnt modulo LINE_WIDTH/8.
REQ-021 line_end SHALL be 1 only in DRAIN with k=7 and grp_cnt=LINE_WIDTH/8-1.
REQ-022 busy SHALL be 1 when state!=FILL or fill_cnt!=0.
REQ-023 Latency: 8th input accepted at cycle N -> ci_start at N+1; ci_done at cycle M -> first pix_out_valid at M+1.
REQ-024 pix_in_ready SHALL be 0 outside FILL; no input is accepted during ISSUE/WAIT/DRAIN.

Reset
REQ-025 Asserting reset SHALL force state FILL and clear fill_cnt, out_cnt, grp_cnt, res_q, ci_dataa and ci_datab, discarding any partial or in-flight group.
REQ-026 Output values during reset: pix_in_ready=1; ci_start, ci_clock_en, pix_out_valid, line_end, busy=0; ci_dataa, ci_datab, pix_out=0.

Configuration
REQ-027 Without SOBEL_FEEDER_THRESH_EN: pix_out SHALL be {nibble,nibble}, so 4'hF gives 8'hFF and 4'h0 gives 8'h00.
REQ-028 With SOBEL_FEEDER_THRESH_EN: pix_out SHALL be 8'hFF when nibble>=THRESH and 8'h00 otherwise.

Structure
REQ-029 The shared package sobel_pkg SHALL hold PIX_PER_WORD=8, PIX_W=8, MAG_W=4 and the FSM state encoding.
REQ-030 Nibble selection and expansion/threshold SHALL live in a combinational sub-module, sobel_nibble_expand.

Verification
REQ-031 Feed pixels 0x01..0x08 -> ci_dataa=0x04030201, ci_datab=0x08070605, ci_start pulse one cycle after the 8th accept.
REQ-032 ci_result=0xF0A50003 with ci_done two cycles after ci_start -> pix_out sequence 33,00,00,00,55,AA,00,FF (no THRESH_EN).
REQ-033 Same result with SOBEL_FEEDER_THRESH_EN and THRESH=8 -> 00,00,00,00,00,FF,00,FF.
REQ-034 pix_out_ready low for 3 cycles at k=2 -> pix_out holds 0x00 with valid high; no nibble skipped; pix_in_ready stays 0.
REQ-035 64 pixels, LINE_WIDTH=64 -> line_end high only on the 64th output pixel; grp_cnt wraps to 0.
REQ-036 Reset asserted in WAIT after 8 accepts -> ci_clock_en=0 and busy=0 immediately; a late ci_done is ignored; the next 8 inputs form a fresh group.
